uart_bfm_engine: RTL and testbench

UART_BFM_ENGINE -- requirements
Module: uart_bfm_engine

---
 rtl/uart_bfm_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_bfm_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bfm_engine.sv
// Full-duplex 8N1 UART engine with CTS-gated transmit, RTS flow control,
// a single-entry receive buffer, frame-error pulse and sticky overrun flag.
module uart_bfm_engine #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_txd,
  input  logic       i_rxd,
  output logic       o_rts,
  input  logic       i_cts,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_rx_frame_err,
  output logic       o_rx_overrun
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  tx_state_t   r_tx_state;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_txd;

  rx_state_t   r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rxd_meta;
  logic        r_rxd_sync;
  logic        r_rxd_prev;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_rts;
  logic        r_rx_frame_err;
  logic        r_rx_overrun;

  logic w_tx_ready;
  logic w_tx_bit_end;
  logic w_rx_bit_end;
  logic w_rx_stop_ok;
  logic w_rx_load;
  logic w_rx_drop;
  logic w_rx_valid_nxt;

  assign w_tx_ready   = (r_tx_state == TX_IDLE) && i_cts && !i_rst;
  assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);
  assign w_rx_bit_end = (r_rx_cnt == BIT_LAST);

  // A good stop bit either fills the buffer (empty or being drained this cycle) or is dropped.
  assign w_rx_stop_ok   = (r_rx_state == RX_STOP) && w_rx_bit_end && r_rxd_sync;
  assign w_rx_load      = w_rx_stop_ok && (!r_rx_valid || i_rx_ready);
  assign w_rx_drop      = w_rx_stop_ok && r_rx_valid && !i_rx_ready;
  assign w_rx_valid_nxt = w_rx_load || (r_rx_valid && !i_rx_ready);

  // Transmit FSM: shifts out start, 8 data bits LSB first, stop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_txd    <= 1'b1;
          r_tx_cnt <= 16'd0;
          r_tx_bit <= 3'd0;
          if (i_tx_valid && w_tx_ready) begin
            r_tx_state <= TX_START;
            r_tx_shift <= i_tx_data;
            r_txd      <= 1'b0;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= 16'd0;
            r_tx_state <= TX_DATA;
            r_txd      <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= 16'd0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= TX_STOP;
              r_txd      <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_txd      <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= 16'd0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        default: begin
          r_tx_state <= TX_IDLE;
          r_tx_cnt   <= 16'd0;
          r_txd      <= 1'b1;
        end
      endcase
    end
  end

  // Receive FSM with input synchronizer, centre sampling and buffer handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_state     <= RX_IDLE;
      r_rx_cnt       <= 16'd0;
      r_rx_bit       <= 3'd0;
      r_rx_shift     <= 8'h00;
      r_rxd_meta     <= 1'b1;
      r_rxd_sync     <= 1'b1;
      r_rxd_prev     <= 1'b1;
      r_rx_data      <= 8'h00;
      r_rx_valid     <= 1'b0;
      r_rts          <= 1'b0;
      r_rx_frame_err <= 1'b0;
      r_rx_overrun   <= 1'b0;
    end else begin
      r_rxd_meta     <= i_rxd;
      r_rxd_sync     <= r_rxd_meta;
      r_rxd_prev     <= r_rxd_sync;
      r_rx_frame_err <= 1'b0;
      r_rx_valid     <= w_rx_valid_nxt;
      r_rts          <= !w_rx_valid_nxt;
      if (w_rx_load) begin
        r_rx_data <= r_rx_shift;
      end
      if (w_rx_drop) begin
        r_rx_overrun <= 1'b1;
      end
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= 16'd0;
          r_rx_bit <= 3'd0;
          // Edge detection means a line stuck low after a bad stop never re-triggers.
          if (r_rxd_prev && !r_rxd_sync) begin
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= 16'd0;
            r_rx_state <= r_rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= 16'd0;
            r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
              r_rx_bit   <= 3'd0;
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (w_rx_bit_end) begin
            r_rx_cnt       <= 16'd0;
            r_rx_state     <= RX_IDLE;
            r_rx_frame_err <= !r_rxd_sync;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
          r_rx_cnt   <= 16'd0;
        end
      endcase
    end
  end

  assign o_txd          = r_txd;
  assign o_tx_ready     = w_tx_ready;
  assign o_rts          = r_rts;
  assign o_rx_data      = r_rx_data;
  assign o_rx_valid     = r_rx_valid;
  assign o_rx_frame_err = r_rx_frame_err;
  assign o_rx_overrun   = r_rx_overrun;

endmodule

// File: tb/tb_uart_bfm_engine.sv
// Directed and randomized checks of uart_bfm_engine against a bench-side
// model of 8N1 framing and the receive-buffer rules.
module tb_uart_bfm_engine;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cts;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rx_ready;
  logic       rxd_drv;
  logic       loop_en;
  logic       cap_en = 1'b0;
  logic       rxd;
  logic       txd;
  logic       rts;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ferr;
  logic       ovr;

  int checks = 0;
  int errors = 0;
  int ferr_cycles;
  int valid_cycles;
  int lb_ferr = 0;
  logic [7:0] rx_got[$];

  assign rxd = loop_en ? txd : rxd_drv;

  uart_bfm_engine #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_txd          (txd),
    .i_rxd          (rxd),
    .o_rts          (rts),
    .i_cts          (cts),
    .i_tx_data      (tx_data),
    .i_tx_valid     (tx_valid),
    .o_tx_ready     (tx_ready),
    .o_rx_data      (rx_data),
    .o_rx_valid     (rx_valid),
    .i_rx_ready     (rx_ready),
    .o_rx_frame_err (ferr),
    .o_rx_overrun   (ovr)
  );

  always #5 clk = ~clk;

  // Collect every byte handed over while the loopback capture is enabled.
  always @(negedge clk) begin
    if (cap_en && rx_valid) rx_got.push_back(rx_data);
    if (cap_en && ferr) lb_ferr++;
  end

  // Line level of serial bit i (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic line_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    else if (i == 9) return 1'b1;
    else return b[i-1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_start(input logic [7:0] b);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Called on the first negedge after acceptance; walks the whole 160-cycle frame.
  task automatic check_tx_frame(input logic [7:0] b, input logic ready_after);
    int bad[10];
    int rdy_hi = 0;
    for (int i = 0; i < 10; i++) bad[i] = 0;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (txd !== line_bit(b, c / CPB)) bad[c / CPB]++;
      if (tx_ready !== 1'b0) rdy_hi++;
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) check($sformatf("tx_0x%02h_bit%0d", b, i), 32'(bad[i]), 32'd0);
    check("tx_ready_low_160", 32'(rdy_hi), 32'd0);
    check("tx_line_idle_after", 32'(txd), 32'd1);
    check("tx_ready_after", 32'(tx_ready), 32'(ready_after));
  endtask

  task automatic sample_rx();
    if (ferr === 1'b1) ferr_cycles++;
    if (rx_valid === 1'b1) valid_cycles++;
  endtask

  task automatic idle_sample(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_rx();
    end
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      rxd_drv = (i == 9) ? stop : line_bit(b, i);
      idle_sample(CPB);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic read_rx();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] lb[8];
    logic [7:0] r1;
    logic [7:0] r2;
    int n;
    int bad_txd;
    int bad_rdy;

    rst = 1'b1; cts = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
    rx_ready = 1'b0; rxd_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rts", 32'(rts), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_frame_err", 32'(ferr), 32'd0);
    check("rst_overrun", 32'(ovr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("post_rst_rts", 32'(rts), 32'd1);

    // 0xA5 frame shape and ready timing.
    send_start(8'hA5);
    check_tx_frame(8'hA5, 1'b1);

    // CTS low blocks acceptance; CTS dropping mid-frame is ignored.
    cts = 1'b0; tx_data = 8'h5A; tx_valid = 1'b1;
    bad_txd = 0; bad_rdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (txd !== 1'b1) bad_txd++;
      if (tx_ready !== 1'b0) bad_rdy++;
    end
    check("cts_block_txd", 32'(bad_txd), 32'd0);
    check("cts_block_ready", 32'(bad_rdy), 32'd0);
    cts = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    cts = 1'b0;
    check_tx_frame(8'h5A, 1'b0);
    cts = 1'b1;

    // Loopback: fixed pair then random bytes, back to back.
    loop_en = 1'b1; rx_ready = 1'b1; cap_en = 1'b1;
    lb[0] = 8'h3C; lb[1] = 8'hC3;
    for (int k = 2; k < 8; k++) lb[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 8; k++) send_start(lb[k]);
    n = 0;
    while (rx_got.size() < 8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("lb_count", 32'(rx_got.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      check($sformatf("lb_byte%0d", k), (k < rx_got.size()) ? 32'(rx_got[k]) : 32'hxxxx_xxxx, 32'(lb[k]));
    check("lb_frame_err", 32'(lb_ferr), 32'd0);
    check("lb_overrun", 32'(ovr), 32'd0);
    cap_en = 1'b0; loop_en = 1'b0; rx_ready = 1'b0;
    repeat (4) @(negedge clk);

    // Overrun: buffer full, second byte dropped.
    ferr_cycles = 0; valid_cycles = 0;
    drive_rx_frame(8'h11, 1'b1);
    drive_rx_frame(8'h22, 1'b1);
    idle_sample(4);
    check("ovr_rx_data", 32'(rx_data), 32'h11);
    check("ovr_rx_valid", 32'(rx_valid), 32'd1);
    check("ovr_flag", 32'(ovr), 32'd1);
    check("ovr_rts_low", 32'(rts), 32'd0);
    read_rx();
    check("ovr_read_valid", 32'(rx_valid), 32'd0);
    check("ovr_read_rts", 32'(rts), 32'd1);
    check("ovr_sticky", 32'(ovr), 32'd1);
    r1 = 8'($urandom_range(0, 255));
    drive_rx_frame(r1, 1'b1);
    idle_sample(4);
    check("rx_rand1_data", 32'(rx_data), 32'(r1));
    check("rx_rand1_valid", 32'(rx_valid), 32'd1);
    read_rx();

    // Bad stop bit, then a short glitch, then a good frame.
    ferr_cycles = 0; valid_cycles = 0;
    drive_rx_frame(8'h55, 1'b0);
    idle_sample(20);
    check("ferr_pulse_cycles", 32'(ferr_cycles), 32'd1);
    check("ferr_valid_cycles", 32'(valid_cycles), 32'd0);
    check("ferr_data_kept", 32'(rx_data), 32'(r1));
    ferr_cycles = 0; valid_cycles = 0;
    rxd_drv = 1'b0;
    idle_sample(4);
    rxd_drv = 1'b1;
    idle_sample(40);
    check("glitch_ferr", 32'(ferr_cycles), 32'd0);
    check("glitch_valid", 32'(valid_cycles), 32'd0);
    r2 = 8'($urandom_range(0, 255));
    drive_rx_frame(r2, 1'b1);
    idle_sample(4);
    check("rx_rand2_data", 32'(rx_data), 32'(r2));
    check("rx_rand2_valid", 32'(rx_valid), 32'd1);
    read_rx();

    // Reset in the middle of a transmit frame.
    send_start(8'h96);
    repeat (100) @(negedge clk);
    check("mid_frame_txd", 32'(txd), 32'(line_bit(8'h96, 101 / CPB)));
    rst = 1'b1;
    @(negedge clk);
    check("abort_txd", 32'(txd), 32'd1);
    check("abort_tx_ready", 32'(tx_ready), 32'd0);
    check("abort_rts", 32'(rts), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_release_ready", 32'(tx_ready), 32'd1);
    check("abort_overrun_cleared", 32'(ovr), 32'd0);
    send_start(8'h0F);
    check_tx_frame(8'h0F, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
